exe_issue_scheduler: RTL and testbench

//  Issue gate between decode and the multi-latency exe stage (1-cycle ALU, N-cycle MUL).
//  - Reserves the single exe->mem result slot per instruction latency (structural hazard).
//  - Tracks per-register pending writes (RAW/WAW hazards).
//  - Issues a request only when it can leave exe in an empty slot and read/write clean regs.
//  - Owns the exe-stage stall; exe only pipelines what this block issues.

---
 rtl/exe_issue_scheduler_pkg.sv | 19 +
 rtl/exe_issue_scheduler_reg_pending_table.sv | 49 ++++
 rtl/exe_issue_scheduler.sv | 94 +++++++++
 tb/tb_exe_issue_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_issue_scheduler_pkg.sv
// Shared types and constants for the exe-stage issue scheduler.
package exe_issue_scheduler_pkg;

  localparam int MAX_EXE_STAGES   = 4;
  localparam int LAT_W            = $clog2(MAX_EXE_STAGES + 1);
  localparam int WB_DELAY_DEFAULT = 2;

  typedef struct packed {
    logic             valid;
    logic [LAT_W-1:0] lat;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             use_rs1;
    logic             use_rs2;
    logic             wr_rd;
  } sched_req_t;

endpackage

// File: rtl/exe_issue_scheduler_reg_pending_table.sv
// Per-register countdown of cycles until a pending write becomes readable by decode.
module reg_pending_table #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ld_en_i,
  input  logic [4:0]       ld_idx_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic [4:0]       rs1_idx_i,
  input  logic [4:0]       rs2_idx_i,
  input  logic [4:0]       rd_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             rd_busy_o,
  output logic [31:0]      busy_o
);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  // A load never meets a nonzero counter, so it simply replaces the decrement.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (ld_en_i && (ld_idx_i == 5'(r))) begin
        cnt_d[r] = ld_val_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) busy_o[r] = (cnt_q[r] != '0);
  end

  assign rs1_busy_o = busy_o[rs1_idx_i];
  assign rs2_busy_o = busy_o[rs2_idx_i];
  assign rd_busy_o  = busy_o[rd_idx_i];

endmodule

// File: rtl/exe_issue_scheduler.sv
// Issue gate into the multi-latency exe stage: result-slot reservation plus
// RAW/WAW tracking; issue_o is combinational from state and the current request.
module exe_issue_scheduler
  import exe_issue_scheduler_pkg::*;
#(
  parameter int MAX_LAT  = MAX_EXE_STAGES,
  parameter int WB_DELAY = WB_DELAY_DEFAULT,
  parameter int CNT_W    = $clog2(MAX_LAT + WB_DELAY + 1)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               req_valid_i,
  input  logic [LAT_W-1:0]   req_lat_i,
  input  logic [4:0]         req_rs1_i,
  input  logic [4:0]         req_rs2_i,
  input  logic [4:0]         req_rd_i,
  input  logic               req_use_rs1_i,
  input  logic               req_use_rs2_i,
  input  logic               req_wr_rd_i,
  input  logic               flush_i,
  output logic               issue_o,
  output logic               stall_o,
  output logic [MAX_LAT-1:0] slot_busy_o,
  output logic [31:0]        reg_busy_o
);

  sched_req_t         req;
  logic [LAT_W-1:0]   lat_eff;
  logic [MAX_LAT-1:0] lat_onehot;
  logic [MAX_LAT-1:0] slot_q, slot_d;
  logic               struct_hz, raw_hz, waw_hz;
  logic               rs1_busy, rs2_busy, rd_busy;
  logic               ld_en;
  logic [CNT_W-1:0]   ld_val;

  always_comb begin
    req = '{valid: req_valid_i, lat: req_lat_i, rs1: req_rs1_i, rs2: req_rs2_i,
            rd: req_rd_i, use_rs1: req_use_rs1_i, use_rs2: req_use_rs2_i,
            wr_rd: req_wr_rd_i};
  end

  // Out-of-range latencies are clamped so hardware never indexes past the slot vector.
  always_comb begin
    lat_eff = req.lat;
    if (req.lat == '0) begin
      lat_eff = LAT_W'(1);
    end else if (req.lat > LAT_W'(MAX_LAT)) begin
      lat_eff = LAT_W'(MAX_LAT);
    end
  end

  assign lat_onehot = MAX_LAT'(1) << (lat_eff - LAT_W'(1));
  assign struct_hz  = |(slot_q & lat_onehot);
  assign raw_hz     = (req.use_rs1 & (req.rs1 != 5'd0) & rs1_busy) |
                      (req.use_rs2 & (req.rs2 != 5'd0) & rs2_busy);
  assign waw_hz     = req.wr_rd & (req.rd != 5'd0) & rd_busy;

  assign issue_o = req.valid & ~flush_i & ~struct_hz & ~raw_hz & ~waw_hz;
  assign stall_o = req.valid & ~issue_o & ~flush_i;

  assign ld_en  = issue_o & req.wr_rd & (req.rd != 5'd0);
  assign ld_val = CNT_W'(lat_eff) + CNT_W'(WB_DELAY);

  assign slot_d = (slot_q | (issue_o ? lat_onehot : '0)) >> 1;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  reg_pending_table #(.CNT_W(CNT_W)) u_pending (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .ld_en_i    (ld_en),
    .ld_idx_i   (req.rd),
    .ld_val_i   (ld_val),
    .rs1_idx_i  (req.rs1),
    .rs2_idx_i  (req.rs2),
    .rd_idx_i   (req.rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy),
    .busy_o     (reg_busy_o)
  );

  assign slot_busy_o = slot_q;

  a_legal_lat: assert property (@(posedge clk_i) disable iff (!rstn_i)
    req_valid_i |-> (req_lat_i != '0) && (req_lat_i <= LAT_W'(MAX_LAT)));

endmodule

// File: tb/tb_exe_issue_scheduler.sv
// Bench for exe_issue_scheduler: fixed cycle-by-cycle vectors, hand sequences
// for reset/throughput, then random traffic against a timestamp-based model.
module tb_exe_issue_scheduler;
  import exe_issue_scheduler_pkg::*;

  localparam int ML = MAX_EXE_STAGES;
  localparam int WB = 2;

  logic             clk = 1'b0;
  logic             rstn_i;
  logic             req_valid_i;
  logic [LAT_W-1:0] req_lat_i;
  logic [4:0]       req_rs1_i, req_rs2_i, req_rd_i;
  logic             req_use_rs1_i, req_use_rs2_i, req_wr_rd_i;
  logic             flush_i;
  logic             issue_o, stall_o;
  logic [ML-1:0]    slot_busy_o;
  logic [31:0]      reg_busy_o;

  exe_issue_scheduler #(.MAX_LAT(ML), .WB_DELAY(WB)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_lat_i(req_lat_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rd_i(req_rd_i),
    .req_use_rs1_i(req_use_rs1_i), .req_use_rs2_i(req_use_rs2_i),
    .req_wr_rd_i(req_wr_rd_i), .flush_i(flush_i), .issue_o(issue_o),
    .stall_o(stall_o), .slot_busy_o(slot_busy_o), .reg_busy_o(reg_busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic v; int lat; int rs1; int rs2; int rd; logic u1; logic u2; logic wr; logic fl;
    logic e_iss; logic e_stl; logic [ML-1:0] e_slot; logic [31:0] e_reg;
  } row_t;

  row_t tbl[23];

  function automatic row_t mk(logic v, int lat, int rs1, int rs2, int rd, logic u1, logic u2,
                              logic wr, logic fl, logic ei, logic es, logic [ML-1:0] sl,
                              logic [31:0] rg);
    row_t r;
    r.v = v; r.lat = lat; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2;
    r.wr = wr; r.fl = fl; r.e_iss = ei; r.e_stl = es; r.e_slot = sl; r.e_reg = rg;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int lat, input int rs1, input int rs2, input int rd,
                       input logic u1, input logic u2, input logic wr, input logic fl);
    req_valid_i = v; req_lat_i = LAT_W'(lat); req_rs1_i = 5'(rs1); req_rs2_i = 5'(rs2);
    req_rd_i = 5'(rd); req_use_rs1_i = u1; req_use_rs2_i = u2; req_wr_rd_i = wr; flush_i = fl;
  endtask

  task automatic check_all(input string tag, input logic ei, input logic es,
                           input logic [ML-1:0] sl, input logic [31:0] rg);
    chk({tag, ".issue"}, 32'(issue_o), 32'(ei));
    chk({tag, ".stall"}, 32'(stall_o), 32'(es));
    chk({tag, ".slot"}, 32'(slot_busy_o), 32'(sl));
    chk({tag, ".reg"}, reg_busy_o, rg);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: absolute exit cycles of in-flight ops and per-register ready cycles.
  int unsigned now;
  int unsigned exits[$];
  int unsigned ready[32];

  function automatic bit m_busy(int r);
    return (r != 0) && (now < ready[r]);
  endfunction

  function automatic bit m_exit_at(int unsigned c);
    foreach (exits[i]) if (exits[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    exits.delete();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    now = 0;
  endtask

  initial begin
    logic ei, es, v, u1, u2, wr, fl, do_rst;
    logic [ML-1:0] sl;
    logic [31:0] rg;
    int lat, rs1, rs2, rd;

    tbl[0]  = mk(1, 3, 1, 2, 5, 1, 1, 1, 0, 1, 0, 4'b0000, 32'h0);
    tbl[1]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 1, 4'b0010, 32'h20);
    tbl[2]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 1, 4'b0001, 32'h20);
    tbl[3]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h20);
    tbl[4]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h20);
    tbl[5]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h20);
    tbl[6]  = mk(1, 1, 5, 0, 6, 1, 0, 1, 0, 1, 0, 4'b0000, 32'h0);
    tbl[7]  = mk(1, 1, 3, 0, 9, 1, 0, 1, 1, 0, 0, 4'b0000, 32'h40);
    tbl[8]  = mk(1, 3, 1, 2, 7, 1, 1, 1, 0, 1, 0, 4'b0000, 32'h40);
    tbl[9]  = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0010, 32'hC0);
    tbl[10] = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0001, 32'h80);
    tbl[11] = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h80);
    tbl[12] = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h80);
    tbl[13] = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 0, 1, 4'b0000, 32'h80);
    tbl[14] = mk(1, 1, 1, 0, 7, 1, 0, 1, 0, 1, 0, 4'b0000, 32'h0);
    tbl[15] = mk(1, 3, 0, 0, 0, 1, 0, 1, 0, 1, 0, 4'b0000, 32'h80);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'h80);
    tbl[17] = mk(1, 1, 2, 0, 13, 1, 0, 1, 0, 0, 1, 4'b0001, 32'h80);
    tbl[18] = mk(1, 1, 2, 0, 13, 1, 0, 1, 0, 1, 0, 4'b0000, 32'h0);
    tbl[19] = mk(1, 4, 1, 2, 10, 1, 1, 1, 0, 1, 0, 4'b0000, 32'h2000);
    tbl[20] = mk(1, 2, 1, 2, 11, 1, 1, 1, 0, 1, 0, 4'b0100, 32'h2400);
    tbl[21] = mk(1, 2, 1, 2, 12, 1, 1, 1, 0, 0, 1, 4'b0011, 32'h2C00);
    tbl[22] = mk(1, 2, 1, 2, 12, 1, 1, 1, 0, 1, 0, 4'b0001, 32'h0C00);

    rstn_i = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b1, 1'b0, '0, 32'h0);
    rstn_i = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].lat, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].u1, tbl[i].u2, tbl[i].wr, tbl[i].fl);
      #3;
      check_all($sformatf("vec%0d", i), tbl[i].e_iss, tbl[i].e_stl, tbl[i].e_slot, tbl[i].e_reg);
      next_cycle();
    end

    // Reset while a MUL to x5 is pending drops the reservation at once.
    drive(1, 3, 1, 2, 5, 1, 1, 1, 0);
    #3;
    chk("rst_seq.mul_issue", 32'(issue_o), 32'd1);
    next_cycle();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b0;
    next_cycle();
    rstn_i = 1'b1;
    drive(1, 1, 5, 0, 0, 1, 0, 0, 0);
    #3;
    check_all("rst_seq.dep", 1'b1, 1'b0, '0, 32'h0);
    next_cycle();

    // Back-to-back independent ALU ops issue every cycle with no slot use.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, 2, 20 + i, 1, 1, 1, 0);
      #3;
      chk($sformatf("alu_stream%0d.issue", i), 32'(issue_o), 32'd1);
      chk($sformatf("alu_stream%0d.slot", i), 32'(slot_busy_o), 32'd0);
      next_cycle();
    end

    rstn_i = 1'b0;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    rstn_i = 1'b1;
    m_reset();

    for (int n = 0; n < 400; n++) begin
      do_rst = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      lat = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, ML));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      drive(v, lat, rs1, rs2, rd, u1, u2, wr, fl);
      if (do_rst) begin
        rstn_i = 1'b0;
        next_cycle();
        rstn_i = 1'b1;
        m_reset();
      end else begin
        ei = v && !fl && !m_exit_at(now + lat - 1) &&
             !(u1 && m_busy(rs1)) && !(u2 && m_busy(rs2)) && !(wr && m_busy(rd));
        es = v && !ei && !fl;
        for (int k = 0; k < ML; k++) sl[k] = m_exit_at(now + k);
        for (int r = 0; r < 32; r++) rg[r] = m_busy(r);
        #3;
        check_all($sformatf("rnd%0d", n), ei, es, sl, rg);
        @(posedge clk);
        if (ei) begin
          exits.push_back(now + lat - 1);
          if (wr && rd != 0) ready[rd] = now + lat + WB + 1;
        end
        now++;
        for (int i = exits.size() - 1; i >= 0; i--) if (exits[i] < now) exits.delete(i);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
